// File: rtl/result_demux.sv
// rtl/result_demux.sv - one-in, N-out result demultiplexer with a one-entry holding slot per channel
// Optional feature: RESULT_DEMUX_DROP_CNT_EN adds a saturating drop_cnt for out-of-range selects.
module result_demux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [N*WIDTH-1:0]   out_data
`ifdef RESULT_DEMUX_DROP_CNT_EN
    ,
    output logic [7:0]           drop_cnt
`endif
);

    localparam int          SEL_SPAN = 2 ** SEL_W;
    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N);

    logic [N-1:0]       slot_valid;
    logic [WIDTH-1:0]   slot_data [N];
    logic [SEL_SPAN-1:0] valid_pad;
    logic [SEL_SPAN-1:0] ready_pad;
    logic               sel_legal;
    logic [N-1:0]       load;

    // Pad to the full select range so indexing with any in_sel value is in bounds.
    always_comb begin
        valid_pad          = '0;
        ready_pad          = '0;
        valid_pad[N-1:0]   = slot_valid;
        ready_pad[N-1:0]   = out_ready;
    end

    assign sel_legal = ({1'b0, in_sel} < N_LIM);
    assign in_ready  = sel_legal ? (!valid_pad[in_sel] | ready_pad[in_sel]) : 1'b1;

    always_comb begin
        load = '0;
        for (int k = 0; k < N; k++) begin
            load[k] = in_valid & in_ready & sel_legal & (in_sel == SEL_W'(k));
        end
    end

    // A load takes priority over a drain so a same-cycle refill stays FULL without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            for (int k = 0; k < N; k++) begin
                slot_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load[k]) begin
                    slot_valid[k] <= 1'b1;
                    slot_data[k]  <= in_data;
                end else if (out_ready[k]) begin
                    slot_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = slot_valid;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_out
            assign out_data[g*WIDTH +: WIDTH] = slot_data[g];
        end
    endgenerate

`ifdef RESULT_DEMUX_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (in_valid && !sel_legal && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_result_demux.sv
// tb/tb_result_demux.sv - scoreboard bench for result_demux (N=4, SEL_W=3 so selects 4..7 are illegal)
module tb_result_demux;

    localparam int W = 32;
    localparam int N = 4;
    localparam int S = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [S-1:0]   in_sel;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic [N*W-1:0] out_data;
`ifdef RESULT_DEMUX_DROP_CNT_EN
    logic [7:0]     drop_cnt;
`endif

    int vectors = 0;
    int errors  = 0;
    logic [W-1:0] exp_q [N][$];

    result_demux #(.WIDTH(W), .N(N), .SEL_W(S)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef RESULT_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the head of that channel's queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("unexpected_word_ch%0d", k), 128'(out_data[k*W +: W]), 128'hDEAD_BEEF_0BAD);
                    end else begin
                        chk($sformatf("data_ch%0d", k), 128'(out_data[k*W +: W]), 128'(exp_q[k].pop_front()));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [S-1:0] s);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 128'(in_ready), 128'd1);
        else if (s < 3'(N)) exp_q[s].push_back(d);
        step();
        in_valid = 1'b0;
    endtask

    task automatic clear_q();
        for (int k = 0; k < N; k++) exp_q[k].delete();
    endtask

    initial begin
        int stalls;
        int bad;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        step();
        step();
        chk("reset_out_valid", 128'(out_valid), 128'h0);
        chk("reset_out_data", 128'(out_data), 128'h0);
        chk("reset_in_ready", 128'(in_ready), 128'd1);
`ifdef RESULT_DEMUX_DROP_CNT_EN
        chk("reset_drop_cnt", 128'(drop_cnt), 128'd0);
`endif
        rst_n = 1'b1;
        step();

        // Basic routing
        out_ready = 4'hF;
        send(32'hDEAD_0001, 3'd1);
        chk("route1_valid", 128'(out_valid), 128'b0010);
        chk("route1_data", 128'(out_data[63:32]), 128'hDEAD_0001);
        send(32'hDEAD_0003, 3'd3);
        chk("route3_valid", 128'(out_valid), 128'b1000);
        chk("route3_data", 128'(out_data[127:96]), 128'hDEAD_0003);
        step();
        chk("route_idle", 128'(out_valid), 128'b0000);

        // Backpressure isolation
        out_ready = 4'b1110;
        send(32'hA000_0000, 3'd0);
        in_valid = 1'b1;
        in_data  = 32'hA000_0001;
        in_sel   = 3'd0;
        @(negedge clk);
        chk("bp_in_ready_blocked", 128'(in_ready), 128'd0);
        chk("bp_held_data", 128'(out_data[31:0]), 128'hA000_0000);
        in_data = 32'hC000_0002;
        in_sel  = 3'd2;
        #1;
        chk("bp_other_ch_ready", 128'(in_ready), 128'd1);
        exp_q[2].push_back(32'hC000_0002);
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("bp_stable_valid", 128'(out_valid[0]), 128'd1);
        chk("bp_stable_data", 128'(out_data[31:0]), 128'hA000_0000);
        out_ready = 4'hF;
        send(32'hA000_0001, 3'd0);
        step();

        // Same-cycle drain and refill
        out_ready = 4'b1101;
        send(32'h1111_1111, 3'd1);
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_data   = 32'h2222_2222;
        in_sel    = 3'd1;
        @(negedge clk);
        chk("refill_in_ready", 128'(in_ready), 128'd1);
        exp_q[1].push_back(32'h2222_2222);
        step();
        chk("refill_valid", 128'(out_valid[1]), 128'd1);
        chk("refill_data", 128'(out_data[63:32]), 128'h2222_2222);
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            in_data = 32'h5000_0000 + 32'(i);
            @(negedge clk);
            if (!in_ready) stalls++;
            else exp_q[1].push_back(in_data);
            step();
        end
        in_valid = 1'b0;
        chk("stream100_stalls", 128'(stalls), 128'd0);
        step();

        // Illegal selects
        chk("illegal_pre_idle", 128'(out_valid), 128'h0);
        bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 32'hBAD0_0000 + 32'(i);
            in_sel  = 3'(4 + (i % 4));
            @(negedge clk);
            if (!in_ready || out_valid != 4'b0000) bad++;
            step();
`ifdef RESULT_DEMUX_DROP_CNT_EN
            if (i == 9) chk("drop_cnt_10", 128'(drop_cnt), 128'd10);
`endif
        end
        in_valid = 1'b0;
        chk("illegal_ready_no_valid", 128'(bad), 128'd0);
`ifdef RESULT_DEMUX_DROP_CNT_EN
        chk("drop_cnt_sat", 128'(drop_cnt), 128'd255);
`endif

        // Mid-run asynchronous reset with slots 0 and 2 FULL
        out_ready = 4'b0000;
        send(32'h0000_AAAA, 3'd0);
        send(32'h0000_CCCC, 3'd2);
        chk("prereset_valid", 128'(out_valid), 128'b0101);
        #2;
        rst_n = 1'b0;
        clear_q();
        #1;
        chk("async_reset_valid", 128'(out_valid), 128'h0);
        chk("async_reset_data", 128'(out_data), 128'h0);
        step();
        rst_n = 1'b1;
        in_sel = 3'd0;
        #1;
        chk("post_reset_in_ready", 128'(in_ready), 128'd1);
`ifdef RESULT_DEMUX_DROP_CNT_EN
        chk("post_reset_drop_cnt", 128'(drop_cnt), 128'd0);
`endif
        step();

        // Random soak
        for (int i = 0; i < 4000; i++) begin
            out_ready = 4'($urandom_range(0, 15));
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 3'($urandom_range(0, 7));
            in_data   = $urandom;
            @(negedge clk);
            if (in_valid && in_ready && in_sel < 3'(N)) exp_q[in_sel].push_back(in_data);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 4'hF;
        step();
        step();
        chk("soak_drained", 128'(out_valid), 128'h0);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("soak_queue_empty_ch%0d", k), 128'(exp_q[k].size()), 128'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
